// File: rtl/inv_cipher_iter_pkg.sv
// inv_cipher_iter_pkg: AES state type, FSM states, inverse S-box
// table and GF(2^8) helpers shared by the iterative inverse cipher.
package inv_cipher_iter_pkg;

    // element [c][r] is column c, row r; [0][0] holds the first byte
    typedef logic [3:0][3:0][7:0] t_opaque_AESState;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } t_fsm;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_cipher_round.sv
// inv_cipher_round: one combinational inverse round.
// s: current state, rk: round key, last: skip InvMixColumns, ns: next state.
module inv_cipher_round
    import inv_cipher_iter_pkg::*;
(
    input  t_opaque_AESState s,
    input  t_opaque_AESState rk,
    input  logic             last,
    output t_opaque_AESState ns
);

    // InvMixColumns row 0 coefficients; row r is this rotated by r
    localparam logic [3:0][7:0] MIX_ROW = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    t_opaque_AESState sr;
    t_opaque_AESState ak;
    t_opaque_AESState mc;

    always_comb begin
        sr = '0;
        ak = '0;
        mc = '0;
        // InvShiftRows: row r rotates right by r columns
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[c][r] = s[2'(c - r)][r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ak[c][r] = INV_SBOX[sr[c][r]] ^ rk[c][r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    mc[c][r] = mc[c][r]
                             ^ gmul(MIX_ROW[2'(k - r)], ak[c][k]);
                end
            end
        end
        ns = last ? ak : mc;
    end

endmodule

// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES inverse cipher, one round per clock.
// in_*: ciphertext handshake, rk_idx/rk_data: external key store,
// out_*: plaintext handshake. rst is asynchronous, active-low.
module inv_cipher_iter
    import inv_cipher_iter_pkg::*;
#(
    parameter int NR = 10
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  t_opaque_AESState in_data,
    output logic [3:0]       rk_idx,
    input  t_opaque_AESState rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output t_opaque_AESState out_data
);

    localparam logic [3:0] LAST_KEY = 4'(NR);

    t_fsm             fsm;
    logic [3:0]       rnd;
    t_opaque_AESState st;
    t_opaque_AESState st_next;
    logic             last_rnd;

    assign last_rnd = (rnd == 4'd0);
    assign out_data = st;

    inv_cipher_round u_round (
        .s    (st),
        .rk   (rk_data),
        .last (last_rnd),
        .ns   (st_next)
    );

    // rk_idx is kept as its own register so the key store sees a
    // glitch-free index: NR in IDLE, rnd in ROUND, 0 in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            rnd       <= 4'd0;
            st        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rk_idx    <= LAST_KEY;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st       <= in_data ^ rk_data;
                        rnd      <= LAST_KEY - 4'd1;
                        rk_idx   <= LAST_KEY - 4'd1;
                        in_ready <= 1'b0;
                        fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    st <= st_next;
                    if (last_rnd) begin
                        out_valid <= 1'b1;
                        rk_idx    <= 4'd0;
                        fsm       <= DONE;
                    end else begin
                        rnd    <= rnd - 4'd1;
                        rk_idx <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        rk_idx    <= LAST_KEY;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter: directed FIPS-197 vectors for inv_cipher_iter
// with NR=10 and NR=14 instances and an in-bench key schedule.
module tb_inv_cipher_iter;
    import inv_cipher_iter_pkg::*;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C1_KEY =
        {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] B_KEY =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst;
    logic key_sel = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]       a_rk_idx;
    t_opaque_AESState a_in_data, a_rk_data, a_out_data;
    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]       b_rk_idx;
    t_opaque_AESState b_in_data, b_rk_data, b_out_data;

    logic [7:0]       sb_tab [256];
    t_opaque_AESState ks_c1 [16];
    t_opaque_AESState ks_b  [16];
    t_opaque_AESState ks_c3 [16];

    always #5 clk = ~clk;

    always_comb a_rk_data = key_sel ? ks_b[a_rk_idx] : ks_c1[a_rk_idx];
    always_comb b_rk_data = ks_c3[b_rk_idx];

    inv_cipher_iter #(.NR(10)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .rk_idx(a_rk_idx), .rk_data(a_rk_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data)
    );

    inv_cipher_iter #(.NR(14)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .rk_idx(b_rk_idx), .rk_data(b_rk_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // forward S-box: multiplicative inverse then affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0]  inv;
        logic [7:0]  s;
        logic [15:0] d;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        end
        d = {inv, inv};
        s = inv ^ 8'h63;
        for (int n = 1; n <= 4; n++) s = s ^ d[15-n -: 8];
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]],
                sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    function automatic t_opaque_AESState round_key(input logic [255:0] key,
                                                   input int nk,
                                                   input int r);
        logic [31:0]      w [60];
        logic [31:0]      t;
        logic [7:0]       rcon;
        t_opaque_AESState k;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (r + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                k[c][rr] = w[4*r+c][31-8*rr -: 8];
        return k;
    endfunction

    function automatic t_opaque_AESState to_state(input logic [127:0] v);
        t_opaque_AESState s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[c][r] = v[127-8*(4*c+r) -: 8];
        return s;
    endfunction

    task automatic test_reset();
        a_in_valid = 1'b1;
        a_in_data = to_state(C1_CT);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
        end
        checks++;
        if (a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
        end
        checks++;
        if (a_rk_idx !== 4'd10) begin
            failures++;
            $display("FAIL reset_rk_idx: got %0d want 10", a_rk_idx);
        end
        checks++;
        if (a_out_data !== '0) begin
            failures++;
            $display("FAIL reset_out_data: got %h want 0", a_out_data);
        end
        checks++;
        if (b_rk_idx !== 4'd14) begin
            failures++;
            $display("FAIL reset_rk_idx_nr14: got %0d want 14", b_rk_idx);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_nr14_hs: got rdy=%b vld=%b want 1 0",
                     b_in_ready, b_out_valid);
        end
        a_in_valid = 1'b0;
        rst = 1'b1;
    endtask

    // accept on the very next edge, then walk every round
    task automatic test_decrypt_c1(input string tag);
        logic [3:0] exp_rk;
        key_sel = 1'b0;
        a_out_ready = 1'b1;
        a_in_data = to_state(C1_CT);
        a_in_valid = 1'b1;
        #1;
        checks++;
        if (a_rk_idx !== 4'd10 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_accept_cycle: got idx=%0d rdy=%b want 10 1",
                     tag, a_rk_idx, a_in_ready);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data = '1;
        for (int e = 0; e < 10; e++) begin
            exp_rk = 4'(9 - e);
            checks++;
            if (a_rk_idx !== exp_rk || a_out_valid !== 1'b0 ||
                a_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_round%0d: got idx=%0d vld=%b rdy=%b want %0d 0 0",
                         tag, e, a_rk_idx, a_out_valid, a_in_ready, exp_rk);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== to_state(C1_PT)) begin
            failures++;
            $display("FAIL %s_plaintext: got vld=%b %h want 1 %h",
                     tag, a_out_valid, a_out_data, to_state(C1_PT));
        end
        checks++;
        if (a_rk_idx !== 4'd0) begin
            failures++;
            $display("FAIL %s_done_rk_idx: got %0d want 0", tag, a_rk_idx);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
            a_rk_idx !== 4'd10) begin
            failures++;
            $display("FAIL %s_idle: got vld=%b rdy=%b idx=%0d want 0 1 10",
                     tag, a_out_valid, a_in_ready, a_rk_idx);
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_data = to_state(C1_CT);
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_data = to_state(B_CT);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== to_state(C1_PT)) begin
            failures++;
            $display("FAIL bp_first: got vld=%b %h want 1 %h",
                     a_out_valid, a_out_data, to_state(C1_PT));
        end
        key_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 ||
                a_out_data !== to_state(C1_PT)) begin
                failures++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b %h want 1 0 %h",
                         i, a_out_valid, a_in_ready, a_out_data,
                         to_state(C1_PT));
            end
        end
        key_sel = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1",
                     a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_reset_mid_round();
        int n;
        a_out_ready = 1'b1;
        a_in_data = to_state(C1_CT);
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        n = 0;
        while (a_rk_idx !== 4'd4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL mid_wait_rnd4: got %0d edges want 5", n);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 ||
            a_rk_idx !== 4'd10 || a_out_data !== '0) begin
            failures++;
            $display("FAIL mid_async_reset: got rdy=%b vld=%b idx=%0d %h want 1 0 10 0",
                     a_in_ready, a_out_valid, a_rk_idx, a_out_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale_valid%0d: got %b want 0",
                         i, a_out_valid);
            end
        end
        rst = 1'b1;
        test_decrypt_c1("after_reset");
    endtask

    task automatic test_back_to_back();
        key_sel = 1'b0;
        a_out_ready = 1'b1;
        a_in_data = to_state(C1_CT);
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_data = to_state(B_CT);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== to_state(C1_PT) ||
            a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got vld=%b rdy=%b %h want 1 0 %h",
                     a_out_valid, a_in_ready, a_out_data, to_state(C1_PT));
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_handshake: got vld=%b rdy=%b want 0 1",
                     a_out_valid, a_in_ready);
        end
        key_sel = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_in_ready !== 1'b0 || a_rk_idx !== 4'd9) begin
            failures++;
            $display("FAIL b2b_second_accept: got rdy=%b idx=%0d want 0 9",
                     a_in_ready, a_rk_idx);
        end
        a_in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_early_valid: got %b want 0", a_out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== to_state(B_PT)) begin
            failures++;
            $display("FAIL b2b_second: got vld=%b %h want 1 %h",
                     a_out_valid, a_out_data, to_state(B_PT));
        end
        @(posedge clk);
        #1;
        key_sel = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got rdy=%b vld=%b want 1 0",
                     a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_nr14();
        logic [3:0] exp_rk;
        b_out_ready = 1'b1;
        b_in_data = to_state(C3_CT);
        b_in_valid = 1'b1;
        #1;
        checks++;
        if (b_rk_idx !== 4'd14 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL nr14_accept_cycle: got idx=%0d rdy=%b want 14 1",
                     b_rk_idx, b_in_ready);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        for (int e = 0; e < 14; e++) begin
            exp_rk = 4'(13 - e);
            checks++;
            if (b_rk_idx !== exp_rk || b_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL nr14_round%0d: got idx=%0d vld=%b want %0d 0",
                         e, b_rk_idx, b_out_valid, exp_rk);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== to_state(C1_PT)) begin
            failures++;
            $display("FAIL nr14_plaintext: got vld=%b %h want 1 %h",
                     b_out_valid, b_out_data, to_state(C1_PT));
        end
        @(posedge clk);
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL nr14_idle: got vld=%b rdy=%b want 0 1",
                     b_out_valid, b_in_ready);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_in_valid = 1'b0;
        a_in_data = '0;
        a_out_ready = 1'b0;
        b_in_valid = 1'b0;
        b_in_data = '0;
        b_out_ready = 1'b0;
        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));
        for (int r = 0; r < 16; r++) begin
            ks_c1[r] = (r <= 10) ? round_key(C1_KEY, 4, r) : '0;
            ks_b[r]  = (r <= 10) ? round_key(B_KEY, 4, r) : '0;
            ks_c3[r] = (r <= 14) ? round_key(C3_KEY, 8, r) : '0;
        end
        test_reset();
        test_decrypt_c1("c1");
        test_backpressure();
        test_reset_mid_round();
        test_back_to_back();
        test_nr14();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
